// File: rtl/rr_mux_arbiter4_if.sv
// Bus bundle for rr_mux_arbiter4: request/data inputs from four sources and the arbitrated grant/select/data outputs.
// When ARB_LOCK_EN is defined the bundle also carries the tenure lock input.
interface rr_mux_arbiter4_if #(
    parameter int DW = 2
);
    logic [3:0]    req;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] mux_out;
    logic          out_valid;

`ifdef ARB_LOCK_EN
    logic          lock;

    modport master (
        output req, d0, d1, d2, d3, lock,
        input  gnt, sel, mux_out, out_valid
    );

    modport slave (
        input  req, d0, d1, d2, d3, lock,
        output gnt, sel, mux_out, out_valid
    );
`else
    modport master (
        output req, d0, d1, d2, d3,
        input  gnt, sel, mux_out, out_valid
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output gnt, sel, mux_out, out_valid
    );
`endif
endinterface

// File: rtl/rr_mux_arbiter4.sv
// Round-robin arbiter for four requesters driving a registered 4:1 data mux with a bounded tenure (MAX_HOLD).
// Optional macro ARB_LOCK_EN adds a lock input that suspends the tenure limit while asserted.
module rr_mux_arbiter4 #(
    parameter int DW       = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_mux_arbiter4_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    hold_q, hold_d;
    logic [DW-1:0] mux_q, mux_d;
    logic          valid_q, valid_d;

    logic          win_found;
    logic [1:0]    win_idx;
    logic [DW-1:0] d_cur;
    logic          lock_on;
    logic          release_now;

`ifdef ARB_LOCK_EN
    assign lock_on = bus.lock;
`else
    assign lock_on = 1'b0;
`endif

    // Scan from the farthest position down to last+1 so the nearest set request overwrites;
    // k=4 wraps onto last itself, making the previous owner the final candidate.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        cand      = '0;
        win_found = 1'b0;
        win_idx   = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        d_cur = bus.d0;
        case (sel_q)
            2'd0: d_cur = bus.d0;
            2'd1: d_cur = bus.d1;
            2'd2: d_cur = bus.d2;
            2'd3: d_cur = bus.d3;
            default: d_cur = bus.d0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        hold_d      = hold_q;
        mux_d       = mux_q;
        valid_d     = |gnt_q;
        release_now = 1'b0;

        // The current grantee's data is captured on every edge it holds the grant, including the releasing one.
        if (|gnt_q) begin
            mux_d = d_cur;
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    hold_d  = 4'd1;
                end
            end

            GRANT: begin
                release_now = !bus.req[last_q] || ((hold_q >= HOLD_MAX) && !lock_on);
                if (release_now) begin
                    if (win_found) begin
                        gnt_d  = 4'b0001 << win_idx;
                        sel_d  = win_idx;
                        last_d = win_idx;
                        hold_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end else begin
                    // Under lock the counter parks at the limit so dropping lock releases on the next edge.
                    hold_d = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 4'd1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 4'd0;
            mux_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            mux_q   <= mux_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.mux_out   = mux_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_mux_arbiter4.sv
// Directed self-checking bench for rr_mux_arbiter4 (DW=2, MAX_HOLD=4); inputs change and outputs are sampled on the falling edge.
// Builds with or without ARB_LOCK_EN; the lock scenario runs only when the macro is defined.
module tb_rr_mux_arbiter4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    rr_mux_arbiter4_if #(.DW(2)) bus ();

    rr_mux_arbiter4 #(.DW(2), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.d0  = 2'd0;
        bus.d1  = 2'd0;
        bus.d2  = 2'd0;
        bus.d3  = 2'd0;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.d0  = 2'($urandom_range(0, 3));
        bus.d1  = 2'($urandom_range(0, 3));
        bus.d2  = 2'($urandom_range(0, 3));
        bus.d3  = 2'($urandom_range(0, 3));
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fails++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fails++; $display("FAIL reset_sel: got %0d expected 0", bus.sel); end
        n_checks++; if (bus.mux_out !== 2'd0) begin n_fails++; $display("FAIL reset_mux: got %b expected 00", bus.mux_out); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fails++; $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fails++; $display("FAIL reset_first_sel: got %0d expected 0", bus.sel); end
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 4'b0100;
        bus.d2  = 2'b10;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fails++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd2) begin n_fails++; $display("FAIL single_sel: got %0d expected 2", bus.sel); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL single_valid_early: got %b expected 0", bus.out_valid); end
        // Tenure limit of 4 expires twice here; the lone requester must be re-granted without a gap.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++; if (bus.gnt !== 4'b0100) begin n_fails++; $display("FAIL single_regrant[%0d]: got %b expected 0100", k, bus.gnt); end
            n_checks++; if (bus.mux_out !== 2'b10 || bus.out_valid !== 1'b1) begin
                n_fails++; $display("FAIL single_data[%0d]: got %b/%b expected 10/1", k, bus.mux_out, bus.out_valid);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [1:0] exp_m;
        apply_reset();
        bus.d0  = 2'd0;
        bus.d1  = 2'd1;
        bus.d2  = 2'd2;
        bus.d3  = 2'd3;
        bus.req = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_g = 4'(1 << ((k / 4) % 4));
            n_checks++; if (bus.gnt !== exp_g) begin n_fails++; $display("FAIL rotation_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_g); end
            if (k >= 1) begin
                exp_m = 2'(((k - 1) / 4) % 4);
                n_checks++; if (bus.mux_out !== exp_m || bus.out_valid !== 1'b1) begin
                    n_fails++; $display("FAIL rotation_data[%0d]: got %b/%b expected %b/1", k, bus.mux_out, bus.out_valid, exp_m);
                end
            end
        end
    endtask

    task automatic test_early_drop();
        apply_reset();
        bus.d1  = 2'b01;
        bus.d3  = 2'b11;
        bus.req = 4'b0010;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fails++; $display("FAIL drop_gnt1: got %b expected 0010", bus.gnt); end
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fails++; $display("FAIL drop_gnt2: got %b expected 0010", bus.gnt); end
        bus.req = 4'b1000;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fails++; $display("FAIL drop_handover: got %b expected 1000", bus.gnt); end
        n_checks++; if (bus.mux_out !== 2'b01 || bus.out_valid !== 1'b1) begin
            n_fails++; $display("FAIL drop_last_d1: got %b/%b expected 01/1", bus.mux_out, bus.out_valid);
        end
        @(negedge clk);
        n_checks++; if (bus.mux_out !== 2'b11 || bus.out_valid !== 1'b1) begin
            n_fails++; $display("FAIL drop_first_d3: got %b/%b expected 11/1", bus.mux_out, bus.out_valid);
        end
    endtask

    task automatic test_idle_return();
        apply_reset();
        bus.d0  = 2'b01;
        bus.req = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fails++; $display("FAIL idle_gnt: got %b expected 0001", bus.gnt); end
        bus.d0 = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.mux_out !== 2'b11) begin n_fails++; $display("FAIL idle_track: got %b expected 11", bus.mux_out); end
        bus.d0  = 2'b10;
        bus.req = 4'b0000;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fails++; $display("FAIL idle_release_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fails++; $display("FAIL idle_release_valid: got %b expected 1", bus.out_valid); end
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL idle_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fails++; $display("FAIL idle_sel: got %0d expected 0", bus.sel); end
        n_checks++; if (bus.mux_out !== 2'b10) begin n_fails++; $display("FAIL idle_mux_hold: got %b expected 10", bus.mux_out); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.d1  = 2'b11;
        bus.req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0010 || bus.out_valid !== 1'b1) begin
            n_fails++; $display("FAIL async_pre: got %b/%b expected 0010/1", bus.gnt, bus.out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fails++; $display("FAIL async_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.sel !== 2'd0) begin n_fails++; $display("FAIL async_sel: got %0d expected 0", bus.sel); end
        n_checks++; if (bus.mux_out !== 2'd0) begin n_fails++; $display("FAIL async_mux: got %b expected 00", bus.mux_out); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fails++; $display("FAIL async_valid: got %b expected 0", bus.out_valid); end
        // A surviving pointer at 1 would pick requester 3 here; a cleared pointer picks 0.
        bus.req = 4'b1001;
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b0001) begin n_fails++; $display("FAIL async_restart: got %b expected 0001", bus.gnt); end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        bus.d2   = 2'b10;
        bus.lock = 1'b1;
        bus.req  = 4'b1100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++; if (bus.gnt !== 4'b0100) begin n_fails++; $display("FAIL lock_hold[%0d]: got %b expected 0100", k, bus.gnt); end
        end
        bus.lock = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fails++; $display("FAIL lock_release: got %b expected 1000", bus.gnt); end
        bus.lock = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.req  = 4'b0000;
        bus.d0   = 2'd0;
        bus.d1   = 2'd0;
        bus.d2   = 2'd0;
        bus.d3   = 2'd0;
`ifdef ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_single();
        test_rotation();
        test_early_drop();
        test_idle_return();
        test_async_reset();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter4.md
Name: rr_mux_arbiter4

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data mux.
- Four requesters each present `req[i]` and a DW-bit data word `d_i`.
- The block grants one requester at a time, drives the mux select, and registers the selected data onto a single shared output with a valid flag.
- Sits in front of any consumer that reads one 2-bit lane out of four sources.

Parameters:
- DW, 2, data width of each `d_i` and of `mux_out`.
- MAX_HOLD, 4, maximum consecutive grant cycles per tenure. Legal range 1..15; the internal hold counter is 4 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i belongs to requester i
- d0  input  DW  data from requester 0
- d1  input  DW  data from requester 1
- d2  input  DW  data from requester 2
- d3  input  DW  data from requester 3
- gnt  output  4  registered one-hot grant, or all zero
- sel  output  2  registered mux select; sel=i selects d_i
- mux_out  output  DW  registered selected data
- out_valid  output  1  mux_out carries data sampled under a grant

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt=4'b0000, sel=2'b00, mux_out=0, out_valid=0.
  - Round-robin pointer last=2'd3, so requester 0 is searched first after reset.
  - hold_cnt=0.
  - Reset asserted mid-tenure clears everything immediately, with no completion of the tenure.
- Search order: from last+1 upward, wrapping 3->0, ending at last itself. The first set req bit wins.
- IDLE:
  - If req==0: stay in IDLE, gnt=0.
  - Else at the edge: winner w is found; gnt=onehot(w), sel=w, last=w, hold_cnt=1, state=GRANT.
  - Latency: req seen at edge N gives gnt high after edge N.
- GRANT (current grantee c):
  - Every edge with gnt[c]=1 samples d_c into mux_out and sets out_valid=1.
  - Data latency is one cycle from gnt.
  - Release condition at an edge: req[c]==0 OR hold_cnt==MAX_HOLD.
  - Release with another request pending: re-arbitrate in the same edge, searching from c+1.
    - The new grant takes effect with no idle bubble; hold_cnt=1.
    - c itself is eligible again only if no other req is set, as the last position in the search.
  - Release with no eligible req: state=IDLE, gnt=0; sel holds c.
  - No release: keep the grant, hold_cnt+1.
- out_valid: equals the registered |gnt of the previous cycle.
  - When out_valid=0, mux_out holds its last value.
  - mux_out is not cleared on release.
- Simultaneous requests: round-robin only, no fixed priority.
  - Under saturating requests every requester receives a tenure within 4*MAX_HOLD cycles.
- A requester dropping req in the same cycle it would be granted is not granted; req is sampled at the edge.
- Data changes on d_c mid-tenure are tracked cycle by cycle.
- The block never drives gnt with more than one bit set.
- Unused state encodings recover to IDLE with gnt=0.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port `lock` (1 bit).
  - While in GRANT and lock=1 at an edge, the MAX_HOLD limit is ignored and hold_cnt saturates at MAX_HOLD.
  - Release then occurs only when req[c]==0.
  - lock has no effect in IDLE.
- Not defined:
  - Port `lock` is absent.
  - The tenure limit is always enforced.

Test Plan:
1. Reset check:
   - Stimulus: rst_n=0 with arbitrary req/data, then release.
   - Required: gnt=0, sel=0, mux_out=0, out_valid=0. First grant after req=4'b1111 goes to requester 0.
2. Single requester:
   - Stimulus: req=4'b0100, d2=2'b10, MAX_HOLD=4.
   - Required: gnt=4'b0100 and sel=2 one cycle after req. mux_out=2'b10 with out_valid=1 one cycle later.
   - After 4 grant cycles it is re-granted with no gap, since it is the only requester.
3. Saturated rotation:
   - Stimulus: req=4'b1111 held for 20 cycles, d_i=i.
   - Required: grant order 0,1,2,3,0. Each tenure lasts exactly 4 cycles. mux_out steps 0,1,2,3, each value held for 4 cycles.
4. Early drop:
   - Stimulus: requester 1 granted, req[1] deasserted after 2 grant cycles, req[3]=1.
   - Required: the next edge gives gnt=4'b1000 with no idle cycle; out_valid stays 1 continuously.
5. Idle return:
   - Stimulus: requester 0 granted, then req drops to 0.
   - Required: gnt=0 and out_valid=0 one cycle later. sel holds 0 and mux_out holds the last d0 value.
6. Async reset mid-tenure:
   - Stimulus: rst_n pulses low between edges while gnt=4'b0010.
   - Required: all outputs are 0 immediately, without waiting for clk. The search restarts at requester 0.
   - With ARB_LOCK_EN defined, lock=1 with req[2] held for 10 cycles gives one uninterrupted grant to 2.
